// File: rtl/fir_tap_scheduler.sv
// Time-multiplexed FIR controller sequencing one multiply-accumulate over a coefficient bank and circular history.
// Optional macro FIR_SYMMETRIC_EN: linear-phase folding with N_TAPS/2 MAC cycles and a half-size coefficient bank.
module fir_tap_scheduler #(
    parameter int N_TAPS = 100,
    parameter int DATA_W = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [DATA_W-1:0]         s_data_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [DATA_W-1:0]         m_data_o,
    input  logic                      coef_we_i,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr_i,
    input  logic [DATA_W-1:0]         coef_wdata_i,
    output logic                      busy_o
);
    localparam int AW    = $clog2(N_TAPS);
    localparam int ACC_W = 2 * DATA_W;
`ifdef FIR_SYMMETRIC_EN
    localparam int COEF_N = N_TAPS / 2;
`else
    localparam int COEF_N = N_TAPS;
`endif
    localparam int MAC_CYC = COEF_N;

    localparam logic [AW-1:0] PTR_LAST = AW'(N_TAPS - 1);
    localparam logic [AW-1:0] K_LAST   = AW'(MAC_CYC - 1);
    localparam logic [AW-1:0] N_MOD    = AW'(N_TAPS);
    localparam logic [AW:0]   COEF_LIM = (AW+1)'(COEF_N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     newest_q, newest_d;
    logic [AW-1:0]     k_q,      k_d;
    logic [ACC_W-1:0]  acc_q,    acc_d;
    logic [DATA_W-1:0] hist_q [N_TAPS];
    logic [DATA_W-1:0] coef_q [COEF_N];

    logic              accept;
    logic              coef_wr_en;
    logic [AW-1:0]     tap_a_idx;
    logic [DATA_W-1:0] coef_cur;
    logic [ACC_W-1:0]  coef_ext;
    logic [ACC_W-1:0]  samp_ext;
    logic [ACC_W-1:0]  prod;

    // Offset back from the newest sample, wrapping inside the N_TAPS-deep ring.
    function automatic logic [AW-1:0] hist_idx(input logic [AW-1:0] base, input logic [AW-1:0] off);
        if (base >= off) begin
            return base - off;
        end
        return base + N_MOD - off;
    endfunction

    assign s_ready_o  = reset_n_i && (state_q == ST_IDLE);
    assign m_valid_o  = (state_q == ST_OUT);
    assign busy_o     = (state_q == ST_MAC) || (state_q == ST_OUT);
    assign m_data_o   = acc_q[DATA_W-1:0];
    assign accept     = s_valid_i && s_ready_o;
    assign coef_wr_en = (state_q == ST_IDLE) && coef_we_i && ({1'b0, coef_addr_i} < COEF_LIM);

    assign tap_a_idx = hist_idx(newest_q, k_q);
    assign coef_cur  = coef_q[k_q];
    assign coef_ext  = {{DATA_W{coef_cur[DATA_W-1]}}, coef_cur};

`ifdef FIR_SYMMETRIC_EN
    logic [AW-1:0]     tap_b_idx;
    logic [DATA_W-1:0] x_a;
    logic [DATA_W-1:0] x_b;
    logic [DATA_W:0]   pre_sum;

    // Mirrored taps share a coefficient, so they are summed before the multiply.
    assign tap_b_idx = hist_idx(newest_q, PTR_LAST - k_q);
    assign x_a       = hist_q[tap_a_idx];
    assign x_b       = hist_q[tap_b_idx];
    assign pre_sum   = {x_a[DATA_W-1], x_a} + {x_b[DATA_W-1], x_b};
    assign samp_ext  = {{(DATA_W-1){pre_sum[DATA_W]}}, pre_sum};
`else
    logic [DATA_W-1:0] x_a;

    assign x_a      = hist_q[tap_a_idx];
    assign samp_ext = {{DATA_W{x_a[DATA_W-1]}}, x_a};
`endif

    // Low ACC_W bits of the product are the same for signed and unsigned operands once sign-extended.
    assign prod = coef_ext * samp_ext;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        newest_d = newest_q;
        k_d      = k_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    newest_d = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
                    acc_d    = '0;
                    k_d      = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + prod;
                if (k_q == K_LAST) begin
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (m_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset also clears the sample ring and coefficient bank so no stale data survives an abort.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            newest_q <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                hist_q[i] <= '0;
            end
            for (int i = 0; i < COEF_N; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            newest_q <= newest_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            if (accept) begin
                hist_q[wr_ptr_q] <= s_data_i;
            end
            if (coef_wr_en) begin
                coef_q[coef_addr_i] <= coef_wdata_i;
            end
        end
    end

endmodule
